// File: rtl/uart_pkg.sv
// Shared UART serializer constants and the state encoding.
// Used by uart_serializer_param.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    PARITY = 3'd3,
    DONE   = 3'd4
  } ser_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  localparam int UART_DW_MIN = 5;
  localparam int UART_DW_MAX = 16;

endpackage

// File: rtl/uart_serializer_param.sv
// UART TX serializer: LSB-first shift of a DATA_WIDTH word, one bit per bit_tick.
// Build macro UART_SER_PARITY_EN appends a parity bit after the data bits.
module uart_serializer_param #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] Parallel_data,
  input  logic                  bit_tick,
  input  logic                  par_odd,
  output logic                  serial_data,
  output logic                  serial_busy,
  output logic                  serial_done
);

  import uart_pkg::*;

  if (DATA_WIDTH < UART_DW_MIN || DATA_WIDTH > UART_DW_MAX) begin : g_bad_width
    $error("uart_serializer_param: DATA_WIDTH out of range");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ser_state_e            state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      cnt;

`ifdef UART_SER_PARITY_EN
  // Untouched copy so parity ignores later Parallel_data changes
  logic [DATA_WIDTH-1:0] word_q;

  // Capture register for the parity source word
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_q <= '0;
    end else if (state == IDLE && load_valid) begin
      word_q <= Parallel_data;
    end
  end
`else
  // par_odd has no function without the parity bit
  logic par_odd_unused;
  assign par_odd_unused = par_odd;
`endif

  // Frame FSM: state, shift register, bit counter and serial line
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      serial_data <= UART_IDLE_LEVEL;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_valid) begin
            shreg <= Parallel_data;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (bit_tick) begin
            serial_data <= shreg[0];
            shreg       <= shreg >> 1;
            cnt         <= CNT_ONE;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_tick) begin
            if (cnt < CNT_LAST) begin
              serial_data <= shreg[0];
              shreg       <= shreg >> 1;
              cnt         <= cnt + CNT_ONE;
            end else begin
`ifdef UART_SER_PARITY_EN
              serial_data <= ^word_q ^ par_odd;
              state       <= PARITY;
`else
              serial_data <= UART_IDLE_LEVEL;
              state       <= DONE;
`endif
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            serial_data <= UART_IDLE_LEVEL;
            state       <= DONE;
          end
        end
        DONE: begin
          cnt         <= '0;
          serial_data <= UART_IDLE_LEVEL;
          state       <= IDLE;
        end
        default: begin
          cnt         <= '0;
          serial_data <= UART_IDLE_LEVEL;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Handshake and status decode from the registered state
  always_comb begin
    load_ready  = 1'b0;
    serial_busy = 1'b0;
    serial_done = 1'b0;
    unique case (1'b1)
      (state == IDLE): load_ready = ~RST;
      (state == DONE): serial_done = 1'b1;
      default:         serial_busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_serializer_param.sv
// Directed bench for uart_serializer_param (DATA_WIDTH 8 and 5 instances).
// Expectations follow UART_SER_PARITY_EN when it is defined.
module tb_uart_serializer_param;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic       a_lv, a_lr, a_tick, a_po, a_sd, a_busy, a_done;
  logic [7:0] a_pd;
  logic       b_lv, b_lr, b_tick, b_po, b_sd, b_busy, b_done;
  logic [4:0] b_pd;

  int n_checks = 0;
  int n_fail   = 0;

  uart_serializer_param #(.DATA_WIDTH(8)) dut_a (
    .CLK(CLK), .RST(RST),
    .load_valid(a_lv), .load_ready(a_lr),
    .Parallel_data(a_pd), .bit_tick(a_tick),
    .par_odd(a_po), .serial_data(a_sd),
    .serial_busy(a_busy), .serial_done(a_done)
  );

  uart_serializer_param #(.DATA_WIDTH(5)) dut_b (
    .CLK(CLK), .RST(RST),
    .load_valid(b_lv), .load_ready(b_lr),
    .Parallel_data(b_pd), .bit_tick(b_tick),
    .par_odd(b_po), .serial_data(b_sd),
    .serial_busy(b_busy), .serial_done(b_done)
  );

  task automatic tick_a();
    repeat (15) @(posedge CLK);
    #1 a_tick = 1'b1;
    @(posedge CLK);
    #1 a_tick = 1'b0;
  endtask

  task automatic tick_b();
    repeat (15) @(posedge CLK);
    #1 b_tick = 1'b1;
    @(posedge CLK);
    #1 b_tick = 1'b0;
  endtask

  task automatic load_a(input logic [7:0] w, input string nm);
    a_pd = w;
    a_lv = 1'b1;
    @(posedge CLK);
    #1 a_lv = 1'b0;
    n_checks++;
    if (a_busy !== 1'b1 || a_lr !== 1'b0 || a_sd !== 1'b1) begin
      n_fail++;
      $display("FAIL %s load: busy=%b ready=%b sd=%b, required 1 0 1",
               nm, a_busy, a_lr, a_sd);
    end
  endtask

  task automatic frame_a(input logic [7:0] w, input logic exp_par,
                         input bit inject, input string nm);
    for (int i = 0; i < 8; i++) begin
      tick_a();
      n_checks++;
      if (a_sd !== w[i] || a_busy !== 1'b1 || a_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s bit%0d: sd=%b busy=%b done=%b, required sd=%b busy=1 done=0",
                 nm, i, a_sd, a_busy, a_done, w[i]);
      end
      if (inject && i == 2) begin
        a_lv = 1'b1;
        a_pd = 8'hFF;
        @(posedge CLK);
        #1 a_lv = 1'b0;
        a_pd = w;
        n_checks++;
        if (a_lr !== 1'b0 || a_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s inject: ready=%b busy=%b, required 0 1",
                   nm, a_lr, a_busy);
        end
      end
    end
`ifdef UART_SER_PARITY_EN
    tick_a();
    n_checks++;
    if (a_sd !== exp_par || a_busy !== 1'b1 || a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s parity: sd=%b busy=%b done=%b, required sd=%b busy=1 done=0",
               nm, a_sd, a_busy, a_done, exp_par);
    end
`else
    if (exp_par === 1'bx) $display("note: parity expectation unset");
`endif
    tick_a();
    n_checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_sd !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done: done=%b busy=%b sd=%b, required 1 0 1",
               nm, a_done, a_busy, a_sd);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (a_done !== 1'b0 || a_lr !== 1'b1 || a_sd !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle: done=%b ready=%b sd=%b, required 0 1 1",
               nm, a_done, a_lr, a_sd);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    a_lv = 1'b0; a_pd = '0; a_tick = 1'b0; a_po = 1'b0;
    b_lv = 1'b0; b_pd = '0; b_tick = 1'b0; b_po = 1'b0;
    repeat (2) @(posedge CLK);
    #1 a_tick = 1'b1;
    a_lv = 1'b1;
    @(posedge CLK);
    #1 a_tick = 1'b0;
    a_lv = 1'b0;
    n_checks++;
    if (a_sd !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0 || a_lr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: sd=%b busy=%b done=%b ready=%b, required 1 0 0 0",
               a_sd, a_busy, a_done, a_lr);
    end
    n_checks++;
    if (b_sd !== 1'b1 || b_busy !== 1'b0 || b_done !== 1'b0 || b_lr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: sd=%b busy=%b done=%b ready=%b, required 1 0 0 0",
               b_sd, b_busy, b_done, b_lr);
    end
    RST = 1'b0;
    #1;
    n_checks++;
    if (a_lr !== 1'b1 || b_lr !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready: a=%b b=%b, required 1 1", a_lr, b_lr);
    end
    @(posedge CLK);
    #1 a_tick = 1'b1;
    @(posedge CLK);
    #1 a_tick = 1'b0;
    n_checks++;
    if (a_sd !== 1'b1 || a_busy !== 1'b0 || a_lr !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_tick: sd=%b busy=%b ready=%b, required 1 0 1",
               a_sd, a_busy, a_lr);
    end
  endtask

  task automatic test_basic();
    load_a(8'hA5, "basic");
    frame_a(8'hA5, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_parity();
    a_po = 1'b0;
    load_a(8'h07, "par_even");
    frame_a(8'h07, 1'b1, 1'b0, "par_even");
    a_po = 1'b1;
    load_a(8'h07, "par_odd");
    frame_a(8'h07, 1'b0, 1'b0, "par_odd");
    a_po = 1'b0;
  endtask

  task automatic test_width5();
    b_pd = 5'h1F;
    b_lv = 1'b1;
    @(posedge CLK);
    #1 b_lv = 1'b0;
    b_pd = 5'h00;
    for (int i = 0; i < 5; i++) begin
      tick_b();
      n_checks++;
      if (b_sd !== 1'b1 || b_busy !== 1'b1 || b_done !== 1'b0) begin
        n_fail++;
        $display("FAIL w5 bit%0d: sd=%b busy=%b done=%b, required 1 1 0",
                 i, b_sd, b_busy, b_done);
      end
    end
`ifdef UART_SER_PARITY_EN
    tick_b();
    n_checks++;
    if (b_sd !== 1'b1 || b_busy !== 1'b1 || b_done !== 1'b0) begin
      n_fail++;
      $display("FAIL w5 parity: sd=%b busy=%b done=%b, required 1 1 0",
               b_sd, b_busy, b_done);
    end
`endif
    tick_b();
    n_checks++;
    if (b_done !== 1'b1 || b_busy !== 1'b0 || b_sd !== 1'b1) begin
      n_fail++;
      $display("FAIL w5 done: done=%b busy=%b sd=%b, required 1 0 1",
               b_done, b_busy, b_sd);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (b_done !== 1'b0 || b_lr !== 1'b1) begin
      n_fail++;
      $display("FAIL w5 idle: done=%b ready=%b, required 0 1", b_done, b_lr);
    end
  endtask

  task automatic test_ignore_load();
    load_a(8'h3C, "ignore");
    frame_a(8'h3C, 1'b0, 1'b1, "ignore");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] w;
    bit seen_done;
    w = 8'h55;
    load_a(w, "abort");
    for (int i = 0; i < 3; i++) begin
      tick_a();
      n_checks++;
      if (a_sd !== w[i]) begin
        n_fail++;
        $display("FAIL abort bit%0d: sd=%b, required %b", i, a_sd, w[i]);
      end
    end
    RST = 1'b1;
    #1;
    n_checks++;
    if (a_sd !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0 || a_lr !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_rst: sd=%b busy=%b done=%b ready=%b, required 1 0 0 0",
               a_sd, a_busy, a_done, a_lr);
    end
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
      if (a_done !== 1'b0) seen_done = 1'b1;
    end
    RST = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
      if (a_done !== 1'b0) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL abort_nodone: done pulse seen=1, required 0");
    end
    load_a(8'h81, "after_abort");
    frame_a(8'h81, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    a_pd = 8'h96;
    a_lv = 1'b1;
    @(posedge CLK);
    #1;
    n_checks++;
    if (a_busy !== 1'b1 || a_lr !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b cap1: busy=%b ready=%b, required 1 0", a_busy, a_lr);
    end
    frame_a(8'h96, 1'b0, 1'b0, "b2b_1");
    a_pd = 8'h4B;
    @(posedge CLK);
    #1;
    n_checks++;
    if (a_busy !== 1'b1 || a_lr !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b cap2: busy=%b ready=%b, required 1 0", a_busy, a_lr);
    end
    frame_a(8'h4B, 1'b0, 1'b0, "b2b_2");
    a_lv = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_width5();
    test_ignore_load();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
